// File: rtl/uart_rx_parser.sv
// Framed-packet parser behind a UART RX FIFO: hunts SOF 0xA5, checks LEN and XOR
// checksum, then replays the buffered payload on a valid/ready stream.
module uart_rx_parser #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] r_data,
  input  logic            rx_empty,
  output logic            rd_uart,
  output logic [DBIT-1:0] out_data,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic            frame_ok,
  output logic            len_err,
  output logic            chk_err,
  output logic [7:0]      drop_cnt
);

  localparam int unsigned IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [DBIT-1:0] SOF   = DBIT'(8'hA5);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_SEND
  } state_t;

  state_t          state;
  logic            byte_vld;
  logic [7:0]      idx;
  logic [7:0]      len;
  logic [DBIT-1:0] chk;
  logic [DBIT-1:0] buf_mem [MAX_LEN];

  logic [7:0]      rx_byte;
  logic [7:0]      idx_inc;
  logic [7:0]      drop_nxt;
  logic            buf_we;
  logic            fetch_ok;

  assign rx_byte  = 8'(r_data);
  assign idx_inc  = idx + 8'd1;
  assign drop_nxt = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
  assign buf_we   = byte_vld && (state == S_PAYLOAD);
  // A checksum byte in flight may move us into SEND, so no fetch may be launched alongside it.
  assign fetch_ok = !rx_empty && !rd_uart && (state != S_SEND) &&
                    !(byte_vld && (state == S_CHK));

  // Payload storage carries no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[IW'(idx)] <= r_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_HUNT;
      byte_vld  <= 1'b0;
      rd_uart   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      len_err   <= 1'b0;
      chk_err   <= 1'b0;
      drop_cnt  <= 8'd0;
      idx       <= 8'd0;
      len       <= 8'd0;
      chk       <= '0;
    end else begin
      rd_uart  <= fetch_ok;
      byte_vld <= rd_uart;
      frame_ok <= 1'b0;
      len_err  <= 1'b0;
      chk_err  <= 1'b0;

      case (state)
        S_HUNT: begin
          if (byte_vld && (r_data == SOF)) state <= S_LEN;
        end
        S_LEN: begin
          if (byte_vld) begin
            if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
              len_err  <= 1'b1;
              drop_cnt <= drop_nxt;
              state    <= S_HUNT;
            end else begin
              len   <= rx_byte;
              idx   <= 8'd0;
              chk   <= r_data;
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_vld) begin
            chk <= chk ^ r_data;
            idx <= idx_inc;
            if (idx == len - 8'd1) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (byte_vld) begin
            if (r_data == chk) begin
              idx       <= 8'd0;
              out_valid <= 1'b1;
              out_data  <= buf_mem[IW'(0)];
              out_last  <= (len == 8'd1);
              state     <= S_SEND;
            end else begin
              chk_err  <= 1'b1;
              drop_cnt <= drop_nxt;
              state    <= S_HUNT;
            end
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              frame_ok  <= 1'b1;
              state     <= S_HUNT;
            end else begin
              idx      <= idx_inc;
              out_data <= buf_mem[IW'(idx_inc)];
              out_last <= (idx_inc == len - 8'd1);
            end
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parser.sv
// Randomized bench for uart_rx_parser: an upstream FIFO model feeds byte streams and a
// frame-level reference parser predicts payload bytes, pulses and drop count.
module tb_uart_rx_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] r_data = 8'd0;
  logic       rx_empty = 1'b1;
  logic       rd_uart;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       frame_ok;
  logic       len_err;
  logic       chk_err;
  logic [7:0] drop_cnt;

  uart_rx_parser #(.DBIT(8), .MAX_LEN(16)) dut (
    .clk(clk), .reset(reset), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .len_err(len_err), .chk_err(chk_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Standard (non-FWFT) FIFO: data appears the cycle after a read; stimulus only appends.
  logic [7:0] fifo_q[$];
  int         rd_ptr = 0;
  always @(posedge clk) begin
    int nxt;
    nxt = rd_ptr;
    if (rd_uart && (rd_ptr < fifo_q.size())) begin
      r_data <= fifo_q[rd_ptr];
      nxt = rd_ptr + 1;
    end
    rd_ptr   <= nxt;
    rx_empty <= (nxt >= fifo_q.size());
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         exp_ev[$];     // 1 frame_ok, 2 len_err, 3 chk_err
  int         exp_drop = 0;

  int         ready_mode = 0; // 0 always ready, 1 random, 2 stall 5 cycles per byte
  int         hold_cnt = 0;
  bit         have_hold = 0;
  logic [7:0] hold_data;
  logic       hold_last;
  logic [7:0] stim[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bump_drop();
    if (exp_drop < 255) exp_drop++;
  endtask

  // Reference parser over a complete byte stream, frame by frame.
  task automatic model_scan(input logic [7:0] s[$]);
    int         i;
    int         ln;
    logic [7:0] x;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= s.size()) break;
      ln = int'(s[i+1]);
      if (ln == 0 || ln > 16) begin
        exp_ev.push_back(2);
        bump_drop();
        i += 2;
        continue;
      end
      if (i + 2 + ln >= s.size()) break;
      x = 8'(ln);
      for (int k = 0; k < ln; k++) x ^= s[i+2+k];
      if (x == s[i+2+ln]) begin
        for (int k = 0; k < ln; k++) begin
          exp_data.push_back(s[i+2+k]);
          exp_last.push_back(k == ln - 1);
        end
        exp_ev.push_back(1);
      end else begin
        exp_ev.push_back(3);
        bump_drop();
      end
      i += ln + 3;
    end
  endtask

  // One clock of observation; out_ready for the coming edge is chosen here.
  task automatic cycle();
    int npulse;
    int code;
    @(negedge clk);
    if (!reset) begin
      have_hold = 0;
      hold_cnt  = 0;
      return;
    end
    if (have_hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(hold_data));
      check("hold_last", 32'(out_last), 32'(hold_last));
    end
    case (ready_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (out_valid && hold_cnt < 5) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else begin
          out_ready = 1'b1;
          hold_cnt  = 0;
        end
      end
      default: out_ready = 1'b1;
    endcase
    npulse = int'(frame_ok) + int'(len_err) + int'(chk_err);
    if (npulse != 0) begin
      check("pulse_excl", 32'(npulse), 32'd1);
      code = frame_ok ? 1 : (len_err ? 2 : 3);
      if (exp_ev.size() == 0) check("event_unexp", 32'(code), 32'd0);
      else check("event", 32'(code), 32'(exp_ev.pop_front()));
    end
    if (out_valid) check("rd_in_send", 32'(rd_uart), 32'd0);
    have_hold = 0;
    if (out_valid && out_ready) begin
      if (exp_data.size() == 0) check("data_unexp", 32'(out_data), 32'hFFFF);
      else begin
        check("out_data", 32'(out_data), 32'(exp_data.pop_front()));
        check("out_last", 32'(out_last), 32'(exp_last.pop_front()));
      end
    end else if (out_valid) begin
      have_hold = 1;
      hold_data = out_data;
      hold_last = out_last;
    end
  endtask

  task automatic send(input logic [7:0] s[$]);
    model_scan(s);
    foreach (s[k]) fifo_q.push_back(s[k]);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int n = 0; n < 6000 && !done; n++) begin
      cycle();
      if (rd_ptr == fifo_q.size() && exp_data.size() == 0 && exp_ev.size() == 0 &&
          !out_valid && !rd_uart) done = 1;
    end
    repeat (4) cycle();
    check(tag, 32'(done), 32'd1);
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    if (!done) begin
      exp_data.delete();
      exp_last.delete();
      exp_ev.delete();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rd", 32'(rd_uart), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_pulses", 32'({frame_ok, len_err, chk_err}), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
  endtask

  function automatic logic [7:0] rand_non_sof();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  initial begin
    logic [7:0] x;
    int         kind;
    int         ln;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;

    // Basic three-byte frame
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send(stim);
    wait_idle("idle_basic");

    // Leading garbage, single-byte frame
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(stim);
    wait_idle("idle_garbage");

    // Bad checksum (correct would be FD)
    stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    send(stim);
    wait_idle("idle_chkerr");

    // Zero length, over-long length, then a good frame
    stim = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(stim);
    wait_idle("idle_lenerr");

    // Backpressure with a second frame already queued; payload carries an A5
    ready_mode = 2;
    stim = '{8'hA5, 8'h03, 8'hA5, 8'h5A, 8'hC3, 8'h03 ^ 8'hA5 ^ 8'h5A ^ 8'hC3,
             8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
    send(stim);
    wait_idle("idle_stall");
    ready_mode = 0;

    // Reset mid-frame abandons it silently
    stim = '{8'hA5, 8'h04, 8'h11};
    foreach (stim[k]) fifo_q.push_back(stim[k]);
    for (int n = 0; n < 200 && rd_ptr != fifo_q.size(); n++) cycle();
    repeat (6) cycle();
    reset = 1'b0;
    exp_drop = 0;
    repeat (2) cycle();
    check_reset_outputs();
    reset = 1'b1;
    stim = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(stim);
    wait_idle("idle_after_reset");

    // Random mix of garbage, good frames and both error kinds under random backpressure
    ready_mode = 1;
    stim.delete();
    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) stim.push_back(rand_non_sof());
      end else if (kind == 2) begin
        stim.push_back(8'hA5);
        stim.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        ln = int'($urandom_range(1, 16));
        stim.push_back(8'hA5);
        stim.push_back(8'(ln));
        x = 8'(ln);
        for (int k = 0; k < ln; k++) begin
          stim.push_back(8'($urandom_range(0, 255)));
          x ^= stim[stim.size()-1];
        end
        if (kind == 3) x ^= 8'($urandom_range(1, 255));
        stim.push_back(x);
      end
    end
    send(stim);
    wait_idle("idle_random");
    ready_mode = 0;

    // Drive the drop counter past its ceiling, then confirm normal operation
    stim.delete();
    for (int f = 0; f < 260; f++) begin
      stim.push_back(8'hA5);
      stim.push_back(8'h00);
    end
    send(stim);
    wait_idle("idle_saturate");
    check("drop_sat", 32'(drop_cnt), 32'd255);
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    send(stim);
    wait_idle("idle_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_parser.md
UART_RX_PARSER -- requirements
Module: uart_rx_parser

Interface
REQ-001 The module SHALL have parameter DBIT, default 8, meaning byte width (fixed 8 in this revision).
REQ-002 The module SHALL have parameter MAX_LEN, default 16, meaning maximum payload bytes per frame (legal range 1..255).
REQ-003 Port clk, input, 1, the only clock; all logic on rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-low reset (0 = in reset).
REQ-005 Port r_data, input, DBIT, byte from upstream RX FIFO; valid the cycle after rd_uart (standard, non-FWFT FIFO).
REQ-006 Port rx_empty, input, 1, upstream RX FIFO empty flag.
REQ-007 Port rd_uart, output, 1, one-cycle read-enable pulse to upstream RX FIFO.
REQ-008 Port out_data, output, DBIT, payload byte of a checked frame.
REQ-009 Port out_valid, output, 1, out_data valid.
REQ-010 Port out_last, output, 1, marks the final payload byte; qualified by out_valid.
REQ-011 Port out_ready, input, 1, downstream accepts the byte when out_valid and out_ready are both 1.
REQ-012 Port frame_ok, output, 1, one-cycle pulse on the cycle the last byte is accepted.
REQ-013 Port len_err, output, 1, one-cycle pulse on an illegal LEN byte.
REQ-014 Port chk_err, output, 1, one-cycle pulse on a checksum mismatch.
REQ-015 Port drop_cnt, output, 8, saturating count of frames dropped by len_err or chk_err.

Function
REQ-016 Frame format SHALL be SOF = 0xA5, then LEN, then LEN payload bytes, then CHK, where CHK = XOR of LEN and all payload bytes.
REQ-017 Byte fetch: the block SHALL pulse rd_uart when rx_empty = 0, no fetch is outstanding and state is not SEND; it SHALL consume r_data on the following cycle (byte_vld); maximum rate is one byte per 2 cycles.
REQ-018 FSM states SHALL be HUNT, LEN, PAYLOAD, CHK and SEND.
REQ-019 HUNT: a byte of 0xA5 -> LEN; any other byte is discarded silently and the FSM stays in HUNT.
REQ-020 LEN: a byte of 0 or greater than MAX_LEN -> pulse len_err, increment drop_cnt, go to HUNT; otherwise store len, clear idx, seed running XOR with LEN, go to PAYLOAD.
REQ-021 PAYLOAD: write the byte to buf[idx], XOR it into the checksum and increment idx; at idx = len-1 go to CHK; 0xA5 inside the payload is ordinary data.
REQ-022 CHK: a byte equal to the running XOR -> clear idx, go to SEND; a mismatch -> pulse chk_err, increment drop_cnt, go to HUNT, and emit no payload.
REQ-023 SEND: out_valid = 1, out_data = buf[idx], out_last = (idx = len-1); on a handshake increment idx; on the handshake of the last byte pulse frame_ok and go to HUNT.
REQ-024 While out_ready = 0, out_data and out_last SHALL hold stable and out_valid SHALL stay 1.
REQ-025 rd_uart SHALL be 0 for the whole of SEND; upstream bytes stay buffered in the FIFO.
REQ-026 An outstanding fetch SHALL still be consumed when it completes, i.e. rd_uart is never issued without a capture cycle following it.
REQ-027 drop_cnt SHALL saturate at 255 and never wrap.
REQ-028 frame_ok, len_err and chk_err SHALL be mutually exclusive and registered.
REQ-029 The payload buffer SHALL be MAX_LEN x DBIT registers, with no reset required on its contents.

Reset
REQ-030 While reset = 0, the FSM SHALL be in HUNT, and rd_uart, out_valid, out_last, frame_ok, len_err, chk_err, out_data, idx, len, checksum and drop_cnt SHALL all be 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame without any error pulse; after release the block hunts for a new SOF.

Verification
REQ-032 Bytes A5 03 11 22 33 03 with out_ready = 1 -> out_data 11, 22, 33; out_last only on 33; one frame_ok pulse; drop_cnt = 0.
REQ-033 Bytes 00 FF A5 01 7E 7F -> the leading 00 and FF are ignored; a single byte 7E is output with out_last = 1; then frame_ok.
REQ-034 Bytes A5 02 AA 55 00 (correct CHK is FD) -> one chk_err pulse; out_valid never asserts; drop_cnt = 1.
REQ-035 Bytes A5 00 and then A5 11 (17 > MAX_LEN) -> two len_err pulses; drop_cnt = 2; the following A5 01 7E 7F is accepted normally.
REQ-036 Valid 3-byte frame with out_ready held 0 for 5 cycles on each byte -> data stable; rd_uart = 0 throughout SEND; next frame queued in the FIFO is parsed afterwards.
REQ-037 Reset pulsed after A5 04 11 -> all outputs 0 and no error pulse; a subsequent A5 01 7E 7F gives a normal frame_ok.
